// File: rtl/snake_pkg.sv
// Shared constants and types for the title-screen renderer.
package snake_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int TITLE_W = 142;
  localparam int TITLE_H = 16;

  localparam logic [11:0] FG_RGB     = 12'hFFF;
  localparam logic [11:0] BG_RGB     = 12'h000;
  localparam logic [11:0] SHADOW_RGB = 12'h444;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } blink_state_e;

endpackage

// File: rtl/title_blink_fsm.sv
// Frame-synchronous blink controller: alternates SHOW/BLANK every
// BLINK_FRAMES frames while enabled. State only moves on frame_start.
module title_blink_fsm
  import snake_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clock_25,
  input  logic resetn,
  input  logic frame_start,
  input  logic enable,
  output logic show
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and frame counter registers.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: dropping enable wins over the phase toggle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_start) begin
      if (!enable) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = SHOW;
            cnt_d   = '0;
          end
          SHOW, BLANK: begin
            if (cnt_q == CNT_LAST) begin
              state_d = (state_q == SHOW) ? BLANK : SHOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign show = (state_q == SHOW);

endmodule

// File: rtl/title_renderer.sv
// Title-screen renderer: maps VGA raster position to title ROM addresses
// and turns the returned bit into a registered, upscaled RGB pixel.
// Optional drop shadow is enabled with `define TITLE_SHADOW_EN.
module title_renderer
  import snake_pkg::*;
#(
  parameter int          TITLE_W      = snake_pkg::TITLE_W,
  parameter int          TITLE_H      = snake_pkg::TITLE_H,
  parameter int          SCALE_LOG2   = 2,
  parameter int          ORIGIN_X     = 36,
  parameter int          ORIGIN_Y     = 120,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = snake_pkg::FG_RGB,
  parameter logic [11:0] BG_RGB       = snake_pkg::BG_RGB
`ifdef TITLE_SHADOW_EN
  ,
  parameter logic [11:0] SHADOW_RGB   = snake_pkg::SHADOW_RGB
`endif
) (
  input  logic        clock_25,
  input  logic        resetn,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic        enable,
  output logic [7:0]  x_count,
  output logic [3:0]  y_count,
  input  logic        rom_data,
  output logic [11:0] pixel_rgb,
  output logic        pixel_valid
);

  // Window bounds in 11 bits so the right/bottom limits never wrap.
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + (TITLE_W << SCALE_LOG2));
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (TITLE_H << SCALE_LOG2));

  logic [10:0] h_ext, v_ext, x_off, y_off;
  logic        in_col, in_row, in_win;
  logic [7:0]  x_count_q, x_count_d;
  logic [3:0]  y_count_q, y_count_d;
  logic        win_d1_q, von_d1_q;
  logic [11:0] pixel_rgb_q, pixel_rgb_d;
  logic        pixel_valid_q;
  logic        show;

  title_blink_fsm #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clock_25   (clock_25),
    .resetn     (resetn),
    .frame_start(frame_start),
    .enable     (enable),
    .show       (show)
  );

  // Window decode and ROM address generation.
  always_comb begin
    h_ext     = {1'b0, h_count};
    v_ext     = {1'b0, v_count};
    x_off     = h_ext - X_LO;
    y_off     = v_ext - Y_LO;
    in_col    = (h_ext >= X_LO) && (h_ext < X_HI);
    in_row    = (v_ext >= Y_LO) && (v_ext < Y_HI);
    in_win    = video_on && in_col && in_row;
    x_count_d = in_win ? 8'(x_off >> SCALE_LOG2) : 8'd0;
    y_count_d = in_row ? 4'(y_off >> SCALE_LOG2) : 4'd0;
  end

  // Stage 1: addresses and alignment flags.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      x_count_q <= '0;
      y_count_q <= '0;
      win_d1_q  <= 1'b0;
      von_d1_q  <= 1'b0;
    end else begin
      x_count_q <= x_count_d;
      y_count_q <= y_count_d;
      win_d1_q  <= in_win;
      von_d1_q  <= video_on;
    end
  end

`ifdef TITLE_SHADOW_EN
  // Shadow tracking: bit of the previous distinct column on this line.
  logic       cur_bit_q, prev_bit_q;
  logic [7:0] x_last_q;
  logic       prev_eff;

  assign prev_eff = (x_count_q != x_last_q) ? cur_bit_q : prev_bit_q;

  // Column history, cleared whenever the previous cycle was outside the window.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      cur_bit_q  <= 1'b0;
      prev_bit_q <= 1'b0;
      x_last_q   <= '0;
    end else if (!win_d1_q) begin
      cur_bit_q  <= 1'b0;
      prev_bit_q <= 1'b0;
      x_last_q   <= '0;
    end else begin
      if (x_count_q != x_last_q) begin
        prev_bit_q <= cur_bit_q;
      end
      cur_bit_q <= rom_data;
      x_last_q  <= x_count_q;
    end
  end
`endif

  // Colour select for stage 2; blanked outside the window or in BLANK/IDLE.
  always_comb begin
    pixel_rgb_d = BG_RGB;
    if (von_d1_q && win_d1_q && show) begin
      if (rom_data) begin
        pixel_rgb_d = FG_RGB;
      end
`ifdef TITLE_SHADOW_EN
      else if (prev_eff) begin
        pixel_rgb_d = SHADOW_RGB;
      end
`endif
    end
  end

  // Stage 2: registered pixel output.
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      pixel_rgb_q   <= BG_RGB;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_rgb_q   <= pixel_rgb_d;
      pixel_valid_q <= von_d1_q;
    end
  end

  assign x_count     = x_count_q;
  assign y_count     = y_count_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_title_renderer.sv
// Directed testbench for title_renderer.
module tb_title_renderer;

  logic        clock_25 = 1'b0;
  logic        resetn;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        video_on;
  logic        frame_start;
  logic        enable;
  logic [7:0]  x_count;
  logic [3:0]  y_count;
  logic        rom_data;
  logic [11:0] pixel_rgb;
  logic        pixel_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #20 clock_25 = ~clock_25;

  title_renderer dut (
    .clock_25   (clock_25),
    .resetn     (resetn),
    .h_count    (h_count),
    .v_count    (v_count),
    .video_on   (video_on),
    .frame_start(frame_start),
    .enable     (enable),
    .x_count    (x_count),
    .y_count    (y_count),
    .rom_data   (rom_data),
    .pixel_rgb  (pixel_rgb),
    .pixel_valid(pixel_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Present one raster position, then the ROM bit a cycle later.
  task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic von,
                       input logic rom, output logic [7:0] x, output logic [3:0] y,
                       output logic [11:0] rgb, output logic pv);
    h_count  = h;
    v_count  = v;
    video_on = von;
    rom_data = 1'b0;
    tick();
    x = x_count;
    y = y_count;
    rom_data = rom;
    tick();
    rgb = pixel_rgb;
    pv  = pixel_valid;
  endtask

  logic [7:0]  px;
  logic [3:0]  py;
  logic [11:0] prgb;
  logic        ppv;

  initial begin
    resetn      = 1'b0;
    h_count     = '0;
    v_count     = '0;
    video_on    = 1'b0;
    frame_start = 1'b0;
    enable      = 1'b0;
    rom_data    = 1'b0;
    #50;
    chk("rst_x", 32'(x_count), 32'd0);
    chk("rst_y", 32'(y_count), 32'd0);
    chk("rst_rgb", 32'(pixel_rgb), 32'h000);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    resetn = 1'b1;
    tick();

    // IDLE before any frame_start: title hidden.
    enable = 1'b1;
    probe(10'd36, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("idle_rgb", 32'(prgb), 32'h000);

    // First frame: SHOW.
    pulse_frame();
    probe(10'd36, 10'd120, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("org_x", 32'(px), 32'd0);
    chk("org_y", 32'(py), 32'd0);
    chk("org_rgb_on", 32'(prgb), 32'hFFF);
    chk("org_valid", 32'(ppv), 32'd1);
    probe(10'd36, 10'd120, 1'b1, 1'b0, px, py, prgb, ppv);
    chk("org_rgb_off", 32'(prgb), 32'h000);

    // Horizontal sweep across the window on row 124.
    v_count  = 10'd124;
    video_on = 1'b1;
    rom_data = 1'b0;
    for (int h = 36; h <= 603; h++) begin
      h_count = 10'(h);
      tick();
      chk($sformatf("sweep_x_h%0d", h), 32'(x_count), 32'((h - 36) / 4));
    end
    chk("sweep_y", 32'(y_count), 32'd1);
    probe(10'd603, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("right_x", 32'(px), 32'd141);
    chk("right_rgb", 32'(prgb), 32'hFFF);
    probe(10'd604, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("past_x", 32'(px), 32'd0);
    chk("past_rgb", 32'(prgb), 32'h000);
    probe(10'd35, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("left_x", 32'(px), 32'd0);
    chk("left_rgb", 32'(prgb), 32'h000);

    // Vertical boundaries.
    probe(10'd100, 10'd183, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("bot_y", 32'(py), 32'd15);
    chk("bot_x", 32'(px), 32'd16);
    chk("bot_rgb", 32'(prgb), 32'hFFF);
    probe(10'd100, 10'd184, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("below_y", 32'(py), 32'd0);
    chk("below_x", 32'(px), 32'd0);
    chk("below_rgb", 32'(prgb), 32'h000);
    probe(10'd100, 10'd119, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("above_rgb", 32'(prgb), 32'h000);

    // video_on low blanks the pixel and its valid flag.
    probe(10'd36, 10'd120, 1'b0, 1'b1, px, py, prgb, ppv);
    chk("voff_rgb", 32'(prgb), 32'h000);
    chk("voff_valid", 32'(ppv), 32'd0);

    // Blink: frames 1..30 SHOW, 31..60 BLANK, 61 SHOW.
    for (int f = 2; f <= 61; f++) begin
      pulse_frame();
      if (f == 30 || f == 31 || f == 60 || f == 61) begin
        probe(10'd200, 10'd130, 1'b1, 1'b1, px, py, prgb, ppv);
        chk($sformatf("blink_f%0d", f), 32'(prgb),
            (f == 31 || f == 60) ? 32'h000 : 32'hFFF);
      end
    end

    // Enable drop takes effect only at the next frame_start.
    enable = 1'b0;
    probe(10'd200, 10'd130, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("en_drop_hold", 32'(prgb), 32'hFFF);
    pulse_frame();
    probe(10'd200, 10'd130, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("en_drop_idle", 32'(prgb), 32'h000);
    enable = 1'b1;
    pulse_frame();
    probe(10'd200, 10'd130, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("re_enable", 32'(prgb), 32'hFFF);

    // Asynchronous reset mid-line.
    h_count  = 10'd100;
    v_count  = 10'd124;
    video_on = 1'b1;
    rom_data = 1'b1;
    tick();
    tick();
    chk("pre_rst_rgb", 32'(pixel_rgb), 32'hFFF);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rgb", 32'(pixel_rgb), 32'h000);
    chk("async_x", 32'(x_count), 32'd0);
    chk("async_valid", 32'(pixel_valid), 32'd0);
    #5;
    resetn = 1'b1;
    probe(10'd100, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("post_rst_idle", 32'(prgb), 32'h000);
    pulse_frame();
    probe(10'd100, 10'd124, 1'b1, 1'b1, px, py, prgb, ppv);
    chk("post_rst_show", 32'(prgb), 32'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
